// File: rtl/nes_pad_pkg.sv
// Shared constants for the NES joypad responder.
//   Button bit indices follow the console's read order (A is shifted out first).
//   PAD_BITS    : width of the pad shift register
//   SYNC_STAGES : flops in each asynchronous-input synchroniser
package nes_pad_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned PAD_BITS    = 8;
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/button_debounce.sv
// Single-button synchroniser and debouncer.
//   clock   : system clock
//   reset   : asynchronous, active-high
//   raw_n   : raw button level, active low, asynchronous to clock
//   db_n    : accepted (debounced) level, active low; 1 = released after reset
// A new level is accepted once the synchronised input has disagreed with the
// accepted level for DEBOUNCE_CYCLES consecutive clocks.
module button_debounce
  import nes_pad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic db_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   raw_s;

  assign raw_s = sync[SYNC_STAGES-1];

  // Synchroniser resets to the released level so reset exit never looks
  // like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '1;
      db_n <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_n};
      if (raw_s != db_n) begin
        if (cnt == CNT_LAST) begin
          db_n <= raw_s;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/nes_joypad_responder.sv
// Device side of an NES controller port: emulates a standard pad's 8-bit
// parallel-in/serial-out register so the console can read board buttons.
//   clock      : system clock, all state on its rising edge
//   reset      : asynchronous, active-high
//   pad_strobe : console latch line (async); high = continuous parallel load
//   pad_clock  : console shift clock (async); shift on its rising edge
//   pad_data   : serial data to console, active low (0 = pressed)
//   btn_raw_n  : raw buttons, active low, {Right,Left,Down,Up,Start,Select,B,A}
//   turbo_en   : bit0 = turbo on A, bit1 = turbo on B
//   read_count : bits shifted since last latch, saturates at 8
//   frame_done : one-cycle pulse when the 8th bit has been shifted out
module nes_joypad_responder
  import nes_pad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [19:0] TURBO_DIV       = 20'd400000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pad_strobe,
  input  logic                pad_clock,
  output logic                pad_data,
  input  logic [PAD_BITS-1:0] btn_raw_n,
  input  logic [1:0]          turbo_en,
  output logic [3:0]          read_count,
  output logic                frame_done
);

  localparam logic [19:0] TURBO_LAST = TURBO_DIV - 20'd1;

  logic [SYNC_STAGES-1:0] strb_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   strb_s;
  logic                   clk_s;
  logic                   clk_q;
  logic                   clk_rise;

  logic [PAD_BITS-1:0]    btn_db;
  logic [PAD_BITS-1:0]    pressed;

  logic [19:0]            turbo_cnt;
  logic                   turbo_ph;

  logic [PAD_BITS-1:0]    sr;
  logic [PAD_BITS-1:0]    sr_next;
  logic [3:0]             rc_next;
  logic                   fd_next;

  // Console line synchronisers and shift-clock edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strb_sync <= '0;
      clk_sync  <= '0;
      clk_q     <= 1'b0;
    end else begin
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], pad_strobe};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], pad_clock};
      clk_q     <= clk_s;
    end
  end

  assign strb_s   = strb_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_q;

  for (genvar i = 0; i < PAD_BITS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw_n(btn_raw_n[i]),
      .db_n (btn_db[i])
    );
  end

  // Free-running turbo phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      turbo_cnt <= '0;
      turbo_ph  <= 1'b0;
    end else if (turbo_cnt == TURBO_LAST) begin
      turbo_cnt <= '0;
      turbo_ph  <= ~turbo_ph;
    end else begin
      turbo_cnt <= turbo_cnt + 20'd1;
    end
  end

  always_comb begin
    pressed = ~btn_db;
    if (turbo_en[0]) pressed[BTN_A] = pressed[BTN_A] & turbo_ph;
    if (turbo_en[1]) pressed[BTN_B] = pressed[BTN_B] & turbo_ph;
  end

  // Strobe has priority over shift clock, like the 4021's parallel load.
  // Shifting fills with 1 (pressed), so the line reads low after 8 bits.
  always_comb begin
    sr_next = sr;
    rc_next = read_count;
    fd_next = 1'b0;
    if (strb_s) begin
      sr_next = pressed;
      rc_next = '0;
    end else if (clk_rise) begin
      sr_next = {1'b1, sr[PAD_BITS-1:1]};
      if (read_count < 4'd8) begin
        rc_next = read_count + 4'd1;
        fd_next = (read_count == 4'd7);
      end
    end
  end

  // pad_data is registered from the next shift-register value so it tracks
  // sr[0] with no extra cycle of latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      pad_data   <= 1'b1;
      read_count <= '0;
      frame_done <= 1'b0;
    end else begin
      sr         <= sr_next;
      pad_data   <= ~sr_next[0];
      read_count <= rc_next;
      frame_done <= fd_next;
    end
  end

endmodule

// File: doc/nes_joypad_responder.md
Name: nes_joypad_responder

Overview:
- Device-side end of the NES controller port: emulates a standard pad's 8-bit parallel-in/serial-out register.
- Driven by the console's strobe and clock lines; returns active-low serial data.
- Lets the NES core (or an external console under test) read physical board buttons.
- Includes input synchronisers, per-button debounce, and optional turbo on A/B.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, clocks a raw button must hold a new level before it is accepted (~2 ms at 24 MHz)
TURBO_DIV, 20'd400000, clocks per turbo phase half-period
CNT_W, 16, width of debounce counter (must hold DEBOUNCE_CYCLES)

Ports:
clock  in  1  system clock; all state is on its rising edge
reset  in  1  asynchronous, active-high reset
pad_strobe  in  1  console latch line, asynchronous to clock
pad_clock  in  1  console shift clock, asynchronous to clock
pad_data  out  1  serial data to console, active low (0 = pressed)
btn_raw_n  in  8  raw buttons, active low, order {Right,Left,Down,Up,Start,Select,B,A} (bit0 = A)
turbo_en  in  2  bit0 = turbo on A, bit1 = turbo on B
read_count  out  4  bits shifted since last latch, saturates at 8
frame_done  out  1  one-cycle pulse when the 8th bit is shifted out

Behaviour:
- Synchronisation:
  - pad_strobe and pad_clock each pass through a 2-flop synchroniser: strb_s, clk_s.
  - clk_rise = clk_s & ~clk_q, where clk_q is clk_s delayed one cycle.
- Debounce (per bit):
  - Raw bit is synchronised, then compared to the accepted state btn_db.
  - On mismatch, a counter increments. When it reaches DEBOUNCE_CYCLES-1, btn_db takes the new value and the counter clears.
  - Any match clears the counter.
  - Reset: btn_db = 8'hFF (all released), counter = 0.
- Turbo:
  - Free-running counter toggles turbo_ph every TURBO_DIV clocks. Reset: counter = 0, turbo_ph = 0.
  - pressed[i] = ~btn_db[i].
  - For A (i=0) with turbo_en[0], and B (i=1) with turbo_en[1]: pressed is ANDed with turbo_ph.
- Shift register sr[7:0] holds pressed bits (1 = pressed). pad_data = ~sr[0], registered. Cases, in priority order:
  1. strb_s = 1: sr <= pressed (continuous reload); read_count <= 0. Clock edges are ignored while strobe is high, matching 4021 parallel-load priority.
  2. clk_rise and strb_s = 0: sr <= {1'b1, sr[7:1]}. Serial input is tied so the console reads 1 (line low) after 8 bits, matching an original pad. If read_count < 8, read_count <= read_count+1; frame_done pulses when read_count goes 7 -> 8.
  3. Otherwise hold.
- Strobe falling edge: no special action. The last loaded value is frozen, and bit A is already presented on pad_data.
- Latency:
  - pad_clock pin rise to pad_data change: 3 clock cycles (2 synchroniser + 1 register).
  - pad_strobe rise to first load visible on pad_data: 3 cycles.
  - Console strobe/clock pulses must be ≥ 3 clock periods; real NES pulses (~0.5 µs+) satisfy this at ≥ 12 MHz.
- Saturation: after 8 shifts, further clocks keep shifting 1s. pad_data stays 0 and read_count stays 8.
- Reset (any time, mid-frame included), all asynchronous:
  - sr = 0, pad_data = 1 (idle, not pressed), read_count = 0, frame_done = 0.
  - Synchronisers = 0, btn_db = 8'hFF.
- Button change mid-frame: no effect on sr until the next strobe.

Decomposition:
- Package nes_pad_pkg:
  - Bit indices BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7.
  - PAD_BITS=8, SYNC_STAGES=2.
- Sub-module button_debounce (one bit, parameters DEBOUNCE_CYCLES/CNT_W), instantiated 8 times.
- Synchronisers, turbo, and the shift register stay in the top module.

Test Plan:
1. Reset released with no buttons pressed -> pad_data=1, read_count=0; strobe pulse then 8 pad_clock pulses -> pad_data=1 throughout, frame_done pulses once, read_count=8.
2. Hold A and Start (btn_raw_n=8'hF6) longer than DEBOUNCE_CYCLES, strobe then shift -> pad_data sequence 0,1,1,0,1,1,1,1 (A first); 9th and 10th clocks -> pad_data=0.
3. Bounce on Up (toggling every DEBOUNCE_CYCLES/4 for 10 toggles, then release) -> btn_db[4] never changes, and a read returns all 1s.
4. Strobe held high while pad_clock pulses 5 times -> read_count stays 0; pad_data tracks bit A. Toggle A during strobe -> pad_data follows 3+DEBOUNCE_CYCLES cycles later.
5. turbo_en=2'b01, A held, frames read every 0.4·TURBO_DIV clocks -> A bit alternates pressed/released across turbo phases; B (held, no turbo) is always 0 on the line.
6. Assert reset after the 3rd shift -> pad_data=1, read_count=0 immediately (async). After release, a strobe and full read returns correct data.
